timer_run_controller: RTL and testbench
=======================================

Name: timer_run_controller

Overview:
- Sequencing controller for the hh:mm:ss stopwatch datapath.
- Turns two raw push-buttons (start/stop, clear) into run/pause/clear commands for the timer. It drives the timer's count-enable and a synchronous clear.
- Compares the running time against a programmable target and raises a timed, blinking alarm when the target is reached.
- Sits between the board buttons/switches and the timer datapath; runs in the 100 Hz clock domain.

Parameters:
- DEBOUNCE_TICKS, 2: consecutive stable samples (one per clock, 10 ms each) required to accept a button level change.
- ALARM_TICKS, 3000: clocks the alarm stays asserted after the target is reached (30 s).
- BLINK_HALF, 50: clocks per alarm_blink half-period (0.5 s).

Ports:
- clk_100Hz  in  1  system clock, 100 Hz
- rst_n  in  1  reset, asynchronous, active-low
- btn_start_raw  in  1  raw start/stop button, asynchronous, active-high
- btn_clear_raw  in  1  raw clear button, asynchronous, active-high
- target_en  in  1  enables target comparison
- target_hour  in  6  target hours, 0-23
- target_min  in  6  target minutes, 0-59
- target_sec  in  6  target seconds, 0-59
- cur_hour  in  6  current timer hours
- cur_min  in  6  current timer minutes
- cur_sec  in  6  current timer seconds
- start_timer  out  1  count enable to the timer datapath
- timer_clr  out  1  one-cycle synchronous clear pulse to the timer datapath
- state  out  2  0=IDLE, 1=RUN, 2=PAUSE, 3=DONE
- alarm  out  1  target-reached alarm
- alarm_blink  out  1  square wave for the LED/buzzer while alarm=1, else 0

Behaviour:
- Reset (asynchronous) forces:
  - state=IDLE
  - start_timer=0, timer_clr=0, alarm=0, alarm_blink=0
  - synchronizers and debounce levels 0
  - all internal counters 0
- Button path, identical for each button:
  - 2-flop synchronizer.
  - Debounced level updates only after the synchronized value has differed from it for DEBOUNCE_TICKS consecutive edges; any agreeing sample resets the debounce count.
  - A press event is the combinational rising edge of the debounced level (debounced & ~debounced_d), one cycle wide. Releases generate no event.
  - Latency from a clean raw rise to the state change: 3+DEBOUNCE_TICKS edges (5 with default).
- Target match:
  - match = target_en & (cur_hour,cur_min,cur_sec == target_hour,target_min,target_sec) & (target != 00:00:00).
  - An all-zero target counts as disabled.
- FSM, evaluated every edge, in priority order:
  - clear_press in any state -> IDLE, timer_clr=1 for exactly the next cycle. Clear beats a same-cycle start_press and a same-cycle match.
  - IDLE: start_press -> RUN.
  - RUN: match -> DONE (match wins over a same-cycle start_press); else start_press -> PAUSE.
  - PAUSE: start_press -> RUN. Match is ignored in PAUSE.
  - DONE: start_press -> IDLE with a timer_clr pulse, identical to clear.
- Outputs:
  - start_timer = (state==RUN), decoded from the state register; no extra latency.
  - state output is the state register.
- Alarm:
  - On entry to DONE: alarm=1, alarm_blink=1, and both the alarm counter and the blink counter load 0.
  - alarm_blink toggles every BLINK_HALF clocks while alarm=1.
  - After ALARM_TICKS clocks in DONE, alarm and alarm_blink drop to 0; the FSM stays in DONE.
  - Leaving DONE clears alarm and alarm_blink on the same edge.
- Count arithmetic:
  - Debounce counter is sized ceil(log2(DEBOUNCE_TICKS+1)).
  - Alarm counter is sized for ALARM_TICKS and saturates; it never wraps.
- Reset mid-operation: asynchronous return to reset values; no timer_clr pulse is issued, because the datapath resets on rst_n itself.
- Buttons held down: only one event per press. A button held through reset produces a press once it is debounced after reset release.

Test Plan:
- Reset release, btn_start_raw held high from cycle 10 → state=RUN and start_timer=1 after edge 15; no timer_clr pulse.
- Bounce: btn_start_raw toggles each cycle for 8 cycles then settles at 0 → no press event; state stays IDLE.
- RUN → press start → PAUSE (start_timer=0); press again → RUN; cur_* held constant while in PAUSE.
- target_en=1, target 00:00:03; cur_sec steps to 3 → next edge: state=DONE, start_timer=0, alarm=1. alarm_blink toggles every 50 clocks. alarm=0 after 3000 clocks; state remains DONE.
- start and clear debounced on the same cycle while in RUN → IDLE with a single 1-cycle timer_clr. Repeat in DONE with a match present → IDLE and alarm=0.
- target_en=1, target 00:00:00, RUN from cleared timer → no transition to DONE. rst_n pulsed low mid-alarm → all outputs 0 immediately.

Source files
------------

// File: rtl/timer_run_controller_if.sv
// rtl/timer_run_controller_if.sv - Button, target and timer-control signals of the stopwatch run controller.
interface timer_run_controller_if;
  logic       btn_start_raw;
  logic       btn_clear_raw;
  logic       target_en;
  logic [5:0] target_hour;
  logic [5:0] target_min;
  logic [5:0] target_sec;
  logic [5:0] cur_hour;
  logic [5:0] cur_min;
  logic [5:0] cur_sec;
  logic       start_timer;
  logic       timer_clr;
  logic [1:0] state;
  logic       alarm;
  logic       alarm_blink;

  modport master (
    output btn_start_raw, btn_clear_raw, target_en,
    output target_hour, target_min, target_sec,
    output cur_hour, cur_min, cur_sec,
    input  start_timer, timer_clr, state, alarm, alarm_blink
  );

  modport slave (
    input  btn_start_raw, btn_clear_raw, target_en,
    input  target_hour, target_min, target_sec,
    input  cur_hour, cur_min, cur_sec,
    output start_timer, timer_clr, state, alarm, alarm_blink
  );
endinterface

// File: rtl/timer_run_controller.sv
// rtl/timer_run_controller.sv - Debounced run/pause/clear sequencing and target alarm for the stopwatch.
module timer_run_controller #(
  parameter int DEBOUNCE_TICKS = 2,
  parameter int ALARM_TICKS    = 3000,
  parameter int BLINK_HALF     = 50
) (
  input  logic                 clk_100Hz,
  input  logic                 rst_n,
  timer_run_controller_if.slave ctrl
);

  localparam int DB_W = $clog2(DEBOUNCE_TICKS + 1);
  localparam int AL_W = $clog2(ALARM_TICKS + 1);
  localparam int BL_W = $clog2(BLINK_HALF + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_TICKS - 1);
  localparam logic [AL_W-1:0] AL_LAST = AL_W'(ALARM_TICKS - 1);
  localparam logic [AL_W-1:0] AL_MAX  = AL_W'(ALARM_TICKS);
  localparam logic [BL_W-1:0] BL_LAST = BL_W'(BLINK_HALF - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Bit 0 is the start/stop button, bit 1 the clear button.
  logic [1:0]      raw, sync1, sync2, deb, deb_d, press;
  logic [DB_W-1:0] db_cnt [2];
  logic            start_press, clear_press, match;

  state_t          state_q, state_nx;
  logic            clr_nx, clr_q;
  logic            alarm_q, blink_q;
  logic [AL_W-1:0] al_cnt;
  logic [BL_W-1:0] bl_cnt;

  assign raw = {ctrl.btn_clear_raw, ctrl.btn_start_raw};

  always_ff @(posedge clk_100Hz or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      deb_d <= '0;
      for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      deb_d <= deb;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == deb[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          deb[i]    <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign press       = deb & ~deb_d;
  assign start_press = press[0];
  assign clear_press = press[1];

  // An all-zero target is treated as "no target".
  assign match = ctrl.target_en
              && ({ctrl.cur_hour, ctrl.cur_min, ctrl.cur_sec} ==
                  {ctrl.target_hour, ctrl.target_min, ctrl.target_sec})
              && ({ctrl.target_hour, ctrl.target_min, ctrl.target_sec} != 18'd0);

  always_ff @(posedge clk_100Hz or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      clr_q   <= 1'b0;
    end else begin
      state_q <= state_nx;
      clr_q   <= clr_nx;
    end
  end

  always_comb begin
    state_nx = state_q;
    clr_nx   = 1'b0;
    if (clear_press) begin
      state_nx = IDLE;
      clr_nx   = 1'b1;
    end else begin
      case (state_q)
        IDLE:    if (start_press) state_nx = RUN;
        RUN: begin
          if (match)            state_nx = DONE;
          else if (start_press) state_nx = PAUSE;
        end
        PAUSE:   if (start_press) state_nx = RUN;
        default: begin
          if (start_press) begin
            state_nx = IDLE;
            clr_nx   = 1'b1;
          end
        end
      endcase
    end
  end

  // The alarm counter parks at ALARM_TICKS once expired so it never wraps back into an alarm.
  always_ff @(posedge clk_100Hz or negedge rst_n) begin
    if (!rst_n) begin
      alarm_q <= 1'b0;
      blink_q <= 1'b0;
      al_cnt  <= '0;
      bl_cnt  <= '0;
    end else if (state_nx != DONE) begin
      alarm_q <= 1'b0;
      blink_q <= 1'b0;
      al_cnt  <= '0;
      bl_cnt  <= '0;
    end else if (state_q != DONE) begin
      alarm_q <= 1'b1;
      blink_q <= 1'b1;
      al_cnt  <= '0;
      bl_cnt  <= '0;
    end else if (alarm_q) begin
      if (al_cnt == AL_LAST) begin
        alarm_q <= 1'b0;
        blink_q <= 1'b0;
        al_cnt  <= AL_MAX;
        bl_cnt  <= '0;
      end else begin
        al_cnt <= al_cnt + 1'b1;
        if (bl_cnt == BL_LAST) begin
          blink_q <= ~blink_q;
          bl_cnt  <= '0;
        end else begin
          bl_cnt <= bl_cnt + 1'b1;
        end
      end
    end
  end

  always_comb begin
    ctrl.start_timer = (state_q == RUN);
    ctrl.state       = state_q;
    ctrl.timer_clr   = clr_q;
    ctrl.alarm       = alarm_q;
    ctrl.alarm_blink = blink_q;
  end

endmodule

// File: tb/tb_timer_run_controller.sv
// tb/tb_timer_run_controller.sv - Randomized bench for timer_run_controller against a history-based reference model.
module tb_timer_run_controller;
  localparam int DEB   = 2;
  localparam int ALARM = 3000;
  localparam int BLINK = 50;
  localparam int IDLE  = 0;
  localparam int RUN   = 1;
  localparam int PAUSE = 2;
  localparam int DONE  = 3;

  logic clk_100Hz = 1'b0;
  logic rst_n     = 1'b0;

  timer_run_controller_if ifc();

  timer_run_controller #(
    .DEBOUNCE_TICKS(DEB),
    .ALARM_TICKS   (ALARM),
    .BLINK_HALF    (BLINK)
  ) dut (
    .clk_100Hz(clk_100Hz),
    .rst_n    (rst_n),
    .ctrl     (ifc.slave)
  );

  always #5 clk_100Hz = ~clk_100Hz;

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  // Model: hist[b][k] is the raw level sampled k+1 edges ago; the level moves once the last DEB
  // samples that have cleared the synchronizer all disagree with it.
  bit hist [2][8];
  bit m_deb  [2];
  bit m_rose [2];
  int m_state;
  bit m_clr;
  int cyc;
  int entry;

  function automatic void model_reset();
    for (int b = 0; b < 2; b++) begin
      for (int k = 0; k < 8; k++) hist[b][k] = 1'b0;
      m_deb[b]  = 1'b0;
      m_rose[b] = 1'b0;
    end
    m_state = IDLE;
    m_clr   = 1'b0;
    entry   = 0;
  endfunction

  function automatic void model_edge();
    bit pr [2];
    bit rw [2];
    bit all_diff;
    bit match;
    int ns;
    rw[0] = ifc.btn_start_raw;
    rw[1] = ifc.btn_clear_raw;
    cyc++;
    match = ifc.target_en
         && ({ifc.cur_hour, ifc.cur_min, ifc.cur_sec} == {ifc.target_hour, ifc.target_min, ifc.target_sec})
         && ({ifc.target_hour, ifc.target_min, ifc.target_sec} != 18'd0);
    for (int b = 0; b < 2; b++) begin
      pr[b]    = m_rose[b];
      all_diff = 1'b1;
      for (int k = 1; k <= DEB; k++) if (hist[b][k] == m_deb[b]) all_diff = 1'b0;
      if (all_diff) m_deb[b] = ~m_deb[b];
      m_rose[b] = all_diff && m_deb[b];
      for (int k = 7; k > 0; k--) hist[b][k] = hist[b][k-1];
      hist[b][0] = rw[b];
    end
    m_clr = 1'b0;
    ns    = m_state;
    if (pr[1]) begin
      ns    = IDLE;
      m_clr = 1'b1;
    end else begin
      case (m_state)
        IDLE:    if (pr[0]) ns = RUN;
        RUN:     if (match) ns = DONE; else if (pr[0]) ns = PAUSE;
        PAUSE:   if (pr[0]) ns = RUN;
        default: if (pr[0]) begin ns = IDLE; m_clr = 1'b1; end
      endcase
    end
    if (ns == DONE && m_state != DONE) entry = cyc;
    m_state = ns;
  endfunction

  task automatic compare_all();
    int k;
    bit ea;
    k  = cyc - entry;
    ea = (m_state == DONE) && (k < ALARM);
    check_eq("state", 32'(ifc.state), 32'(m_state));
    check_eq("start_timer", 32'(ifc.start_timer), 32'(m_state == RUN));
    check_eq("timer_clr", 32'(ifc.timer_clr), 32'(m_clr));
    check_eq("alarm", 32'(ifc.alarm), 32'(ea));
    check_eq("alarm_blink", 32'(ifc.alarm_blink), 32'(ea && ((k / BLINK) % 2 == 0)));
  endtask

  task automatic tick();
    @(posedge clk_100Hz);
    if (rst_n) model_edge();
    else       model_reset();
    #1;
    compare_all();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_btn(input int b, input bit v);
    if (b == 0) ifc.btn_start_raw = v;
    else        ifc.btn_clear_raw = v;
  endtask

  task automatic press(input int b, input int hold, input int bounce);
    for (int i = 0; i < bounce; i++) begin
      set_btn(b, 1'($urandom_range(0, 1)));
      tick();
    end
    set_btn(b, 1'b1);
    ticks(hold);
    set_btn(b, 1'b0);
    ticks(DEB + 4);
  endtask

  task automatic set_cur(input int h, input int m, input int s);
    ifc.cur_hour = 6'(h);
    ifc.cur_min  = 6'(m);
    ifc.cur_sec  = 6'(s);
  endtask

  task automatic set_target(input bit en, input int h, input int m, input int s);
    ifc.target_en   = en;
    ifc.target_hour = 6'(h);
    ifc.target_min  = 6'(m);
    ifc.target_sec  = 6'(s);
  endtask

  task automatic both_press();
    ifc.btn_start_raw = 1'b1;
    ifc.btn_clear_raw = 1'b1;
    ticks(3);
    ifc.btn_start_raw = 1'b0;
    ifc.btn_clear_raw = 1'b0;
  endtask

  int n;
  int pulses;

  initial begin
    ifc.btn_start_raw = 1'b0;
    ifc.btn_clear_raw = 1'b0;
    set_target(1'b0, 0, 0, 0);
    set_cur(0, 0, 0);
    cyc = 0;
    model_reset();
    #1;
    compare_all();
    ticks(3);
    rst_n = 1'b1;

    // Clean start press held from cycle 10: five edges to RUN.
    ticks(9);
    ifc.btn_start_raw = 1'b1;
    n = 0;
    while (ifc.state != 2'(RUN) && n < 20) begin
      tick();
      n++;
    end
    check_eq("start_latency", 32'(n), 32'(3 + DEB));
    ifc.btn_start_raw = 1'b0;
    ticks(6);

    press(1, 3, 0);
    check_eq("clear_to_idle", 32'(ifc.state), 32'(IDLE));

    // Bounce: alternating samples never debounce.
    for (int i = 0; i < 8; i++) begin
      ifc.btn_start_raw = ~ifc.btn_start_raw;
      tick();
    end
    ifc.btn_start_raw = 1'b0;
    ticks(8);
    check_eq("bounce_idle", 32'(ifc.state), 32'(IDLE));

    set_cur(1, 2, 3);
    press(0, 3, 0);
    check_eq("run", 32'(ifc.state), 32'(RUN));
    press(0, 4, 0);
    check_eq("pause", 32'(ifc.state), 32'(PAUSE));
    check_eq("pause_start_timer", 32'(ifc.start_timer), 32'(0));
    press(0, 2, 0);
    check_eq("resume", 32'(ifc.state), 32'(RUN));

    // Start and clear together in RUN.
    pulses = 0;
    both_press();
    for (int i = 0; i < 10; i++) begin
      tick();
      if (ifc.timer_clr) pulses++;
    end
    check_eq("both_clr_pulses", 32'(pulses), 32'(1));
    check_eq("both_idle", 32'(ifc.state), 32'(IDLE));

    // Alarm at 00:00:03.
    set_cur(0, 0, 0);
    set_target(1'b1, 0, 0, 3);
    press(0, 3, 0);
    set_cur(0, 0, 3);
    tick();
    check_eq("done_state", 32'(ifc.state), 32'(DONE));
    check_eq("done_alarm", 32'(ifc.alarm), 32'(1));
    ticks(ALARM + 20);
    check_eq("alarm_expired", 32'(ifc.alarm), 32'(0));
    check_eq("done_holds", 32'(ifc.state), 32'(DONE));

    pulses = 0;
    both_press();
    for (int i = 0; i < 3; i++) begin
      tick();
      if (ifc.timer_clr) pulses++;
    end
    check_eq("done_clr_pulses", 32'(pulses), 32'(1));
    check_eq("done_clear_alarm", 32'(ifc.alarm), 32'(0));
    check_eq("done_clear_idle", 32'(ifc.state), 32'(IDLE));
    set_cur(0, 0, 0);
    ticks(8);

    // Zero target never matches.
    set_target(1'b1, 0, 0, 0);
    press(0, 3, 0);
    ticks(10);
    check_eq("zero_target_run", 32'(ifc.state), 32'(RUN));

    // Back into DONE, then reset in the middle of the alarm.
    set_target(1'b1, 0, 0, 3);
    set_cur(0, 0, 3);
    ticks(2);
    ticks(120);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_eq("rst_state", 32'(ifc.state), 32'(IDLE));
    check_eq("rst_alarm", 32'(ifc.alarm), 32'(0));
    check_eq("rst_blink", 32'(ifc.alarm_blink), 32'(0));
    check_eq("rst_clr", 32'(ifc.timer_clr), 32'(0));
    check_eq("rst_start", 32'(ifc.start_timer), 32'(0));
    ticks(3);
    rst_n = 1'b1;
    set_cur(0, 0, 0);
    ticks(4);

    for (int it = 0; it < 400; it++) begin
      case ($urandom_range(0, 5))
        0, 1: press(0, $urandom_range(1, 6), $urandom_range(0, 3));
        2:    press(1, $urandom_range(1, 6), $urandom_range(0, 3));
        3: begin
          if ($urandom_range(0, 3) == 0)
            set_target(1'($urandom_range(0, 1)), 0, 0, 0);
          else
            set_target(1'($urandom_range(0, 1)), $urandom_range(0, 23),
                       $urandom_range(0, 59), $urandom_range(0, 59));
          tick();
        end
        4: begin
          if ($urandom_range(0, 2) == 0)
            set_cur(ifc.target_hour, ifc.target_min, ifc.target_sec);
          else
            set_cur($urandom_range(0, 23), $urandom_range(0, 59), $urandom_range(0, 59));
          ticks($urandom_range(1, 4));
        end
        default: begin
          for (int i = 0; i < $urandom_range(1, 6); i++) begin
            ifc.btn_start_raw = 1'($urandom_range(0, 1));
            ifc.btn_clear_raw = 1'($urandom_range(0, 1));
            tick();
          end
          ifc.btn_start_raw = 1'b0;
          ifc.btn_clear_raw = 1'b0;
          ticks(6);
        end
      endcase
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
